// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage Otter pipe: turns hazard and memory-busy flags into
// PC/stage-register enables, per-stage valid bits and saturating stall/flush event counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int BOOT_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_use_haz,
    input  logic             control_haz,
    input  logic             dmem_busy,
    input  logic             fetch_valid,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             de_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MSTALL
    } state_t;

    localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] boot_cnt;
    logic [3:0] boot_cnt_nxt;
    logic       mem_stall;
    logic       ch;
    logic       lu;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        boot_cnt_nxt = boot_cnt;
        mem_stall    = 1'b0;
        ch           = 1'b0;
        lu           = 1'b0;
        pc_we        = 1'b0;
        if_de_we     = 1'b0;
        de_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;

        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    boot_cnt_nxt = boot_cnt + 4'd1;
                end
            end
            default: begin
                // In MSTALL mem_valid is frozen high, so only dmem_busy decides whether the stall persists.
                mem_stall = dmem_busy && ((state == ST_MSTALL) || mem_valid);
                ch        = !mem_stall && control_haz && ex_valid;
                lu        = !mem_stall && !ch && load_use_haz && de_valid && ex_valid;
                state_nxt = mem_stall ? ST_MSTALL : ST_RUN;
                if (!mem_stall) begin
                    pc_we     = !lu;
                    if_de_we  = !lu;
                    de_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                    mem_wb_we = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_BOOT;
            boot_cnt  <= '0;
            de_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_cnt_nxt;

            // de_ex_we is high exactly on advancing cycles (normal, redirect or load-use bubble).
            if (de_ex_we) begin
                de_valid  <= ch ? 1'b0 : (lu ? de_valid : fetch_valid);
                ex_valid  <= (ch || lu) ? 1'b0 : de_valid;
                mem_valid <= ex_valid;
                wb_valid  <= mem_valid;
            end

            if ((mem_stall || lu) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (ch && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: a 16-bit and a 4-bit counter instance share stimulus and are checked
// against a stage-occupancy reference model, with directed scenarios followed by random traffic.
module tb_pipeline_stall_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic lu_in, ch_in, busy_in, fv_in;

    // {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, de_valid, ex_valid, mem_valid, wb_valid}
    wire [8:0]  flags_a;
    wire [8:0]  flags_b;
    wire [15:0] stall_a, flush_a;
    wire [3:0]  stall_b, flush_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stage occupancy, remaining boot cycles, unbounded event totals.
    int boot_left;
    bit m_de, m_ex, m_mem, m_wb;
    int m_stall, m_flush;

    pipeline_stall_ctrl #(.CNT_W(16), .BOOT_CYCLES(2)) dut_a (
        .CLK(CLK), .RST(RST),
        .load_use_haz(lu_in), .control_haz(ch_in), .dmem_busy(busy_in), .fetch_valid(fv_in),
        .pc_we(flags_a[8]), .if_de_we(flags_a[7]), .de_ex_we(flags_a[6]),
        .ex_mem_we(flags_a[5]), .mem_wb_we(flags_a[4]),
        .de_valid(flags_a[3]), .ex_valid(flags_a[2]), .mem_valid(flags_a[1]), .wb_valid(flags_a[0]),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipeline_stall_ctrl #(.CNT_W(4), .BOOT_CYCLES(2)) dut_b (
        .CLK(CLK), .RST(RST),
        .load_use_haz(lu_in), .control_haz(ch_in), .dmem_busy(busy_in), .fetch_valid(fv_in),
        .pc_we(flags_b[8]), .if_de_we(flags_b[7]), .de_ex_we(flags_b[6]),
        .ex_mem_we(flags_b[5]), .mem_wb_we(flags_b[4]),
        .de_valid(flags_b[3]), .ex_valid(flags_b[2]), .mem_valid(flags_b[1]), .wb_valid(flags_b[0]),
        .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hffff : 16'(v);
    endfunction

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hf : 4'(v);
    endfunction

    task automatic model_reset();
        boot_left = 2;
        m_de = 0; m_ex = 0; m_mem = 0; m_wb = 0;
        m_stall = 0; m_flush = 0;
    endtask

    // Called just after a rising edge: drives one cycle, compares at the falling edge, advances the model.
    task automatic apply_cycle(input bit lu, input bit ch, input bit busy, input bit fv,
                               output logic [8:0] seen);
        int kind;  // 0 boot, 1 mem stall, 2 redirect, 3 load-use, 4 normal
        logic [8:0] exp_f;
        lu_in = lu; ch_in = ch; busy_in = busy; fv_in = fv;
        if (boot_left > 0)            kind = 0;
        else if (busy && m_mem)       kind = 1;
        else if (ch && m_ex)          kind = 2;
        else if (lu && m_de && m_ex)  kind = 3;
        else                          kind = 4;
        case (kind)
            0, 1:    exp_f[8:4] = 5'b00000;
            3:       exp_f[8:4] = 5'b00111;
            default: exp_f[8:4] = 5'b11111;
        endcase
        exp_f[3:0] = {m_de, m_ex, m_mem, m_wb};

        @(negedge CLK);
        n_vec++;
        if (flags_a !== exp_f) begin
            n_err++;
            $display("FAIL flags_w16: got %b expected %b", flags_a, exp_f);
        end
        n_vec++;
        if (flags_b !== exp_f) begin
            n_err++;
            $display("FAIL flags_w4: got %b expected %b", flags_b, exp_f);
        end
        n_vec++;
        if (stall_a !== sat16(m_stall)) begin
            n_err++;
            $display("FAIL stall_w16: got %0d expected %0d", stall_a, sat16(m_stall));
        end
        n_vec++;
        if (flush_a !== sat16(m_flush)) begin
            n_err++;
            $display("FAIL flush_w16: got %0d expected %0d", flush_a, sat16(m_flush));
        end
        n_vec++;
        if (stall_b !== sat4(m_stall)) begin
            n_err++;
            $display("FAIL stall_w4: got %0d expected %0d", stall_b, sat4(m_stall));
        end
        n_vec++;
        if (flush_b !== sat4(m_flush)) begin
            n_err++;
            $display("FAIL flush_w4: got %0d expected %0d", flush_b, sat4(m_flush));
        end
        seen = flags_a;

        @(posedge CLK);
        case (kind)
            0: boot_left--;
            1: m_stall++;
            2: begin m_wb = m_mem; m_mem = m_ex; m_ex = 0; m_de = 0; m_flush++; end
            3: begin m_wb = m_mem; m_mem = m_ex; m_ex = 0; m_stall++; end
            default: begin m_wb = m_mem; m_mem = m_ex; m_ex = m_de; m_de = fv; end
        endcase
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        lu_in = 0; ch_in = 0; busy_in = 0; fv_in = 0;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic run_normal(input int n);
        logic [8:0] s;
        for (int i = 0; i < n; i++) apply_cycle(0, 0, 0, 1, s);
    endtask

    task automatic test_reset();
        logic [8:0] s;
        RST = 1'b1;
        lu_in = 0; ch_in = 0; busy_in = 0; fv_in = 1;
        @(posedge CLK);
        #1;
        n_vec++;
        if ({flags_a, flags_b, stall_a, flush_a, stall_b, flush_b} !== 58'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b/%b %0d %0d %0d %0d expected all zero",
                     flags_a, flags_b, stall_a, flush_a, stall_b, flush_b);
        end
        model_reset();
        RST = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            apply_cycle(0, 0, 0, 1, s);
            n_vec++;
            if (s[8] !== (k > 2)) begin
                n_err++;
                $display("FAIL boot_pc_we cycle %0d: got %b expected %b", k, s[8], (k > 2));
            end
            n_vec++;
            if (flags_a[0] !== (k >= 6)) begin
                n_err++;
                $display("FAIL boot_wb_valid edge %0d: got %b expected %b", k, flags_a[0], (k >= 6));
            end
        end
    endtask

    task automatic test_load_use();
        logic [8:0] s;
        do_reset();
        run_normal(5);
        apply_cycle(1, 0, 0, 1, s);
        n_vec++;
        if (s[8:7] !== 2'b00 || s[6] !== 1'b1) begin
            n_err++;
            $display("FAIL lu_enables: got %b expected 001", s[8:6]);
        end
        n_vec++;
        if (flags_a[3:2] !== 2'b10 || stall_a !== 16'd1) begin
            n_err++;
            $display("FAIL lu_bubble: got de/ex %b stall %0d expected 10 stall 1", flags_a[3:2], stall_a);
        end
    endtask

    task automatic test_control();
        logic [8:0] s;
        do_reset();
        run_normal(5);
        apply_cycle(0, 1, 0, 1, s);
        n_vec++;
        if (flags_a[3:1] !== 3'b001 || flush_a !== 16'd1) begin
            n_err++;
            $display("FAIL ch_squash: got de/ex/mem %b flush %0d expected 001 flush 1", flags_a[3:1], flush_a);
        end
        // ex_valid is now 0, so the redirect request must be ignored.
        apply_cycle(0, 1, 0, 1, s);
        n_vec++;
        if (s[8] !== 1'b1 || flags_a[3] !== 1'b1 || flush_a !== 16'd1) begin
            n_err++;
            $display("FAIL ch_no_ex: got pc_we %b de %b flush %0d expected 1 1 1", s[8], flags_a[3], flush_a);
        end
    endtask

    task automatic test_ch_and_lu();
        logic [8:0] s;
        do_reset();
        run_normal(5);
        apply_cycle(1, 1, 0, 1, s);
        n_vec++;
        if (s[8] !== 1'b1 || flush_a !== 16'd1 || stall_a !== 16'd0) begin
            n_err++;
            $display("FAIL ch_lu: got pc_we %b flush %0d stall %0d expected 1 1 0", s[8], flush_a, stall_a);
        end
    endtask

    task automatic test_mem_stall();
        logic [8:0] s;
        do_reset();
        run_normal(5);
        for (int i = 0; i < 3; i++) begin
            apply_cycle(0, 1, 1, 1, s);
            n_vec++;
            if (s[8:4] !== 5'b00000 || flags_a[3:0] !== 4'b1110) begin
                n_err++;
                $display("FAIL mstall_freeze %0d: got we %b valid %b expected 00000 1110", i, s[8:4], flags_a[3:0]);
            end
        end
        n_vec++;
        if (stall_a !== 16'd3 || flush_a !== 16'd0) begin
            n_err++;
            $display("FAIL mstall_count: got stall %0d flush %0d expected 3 0", stall_a, flush_a);
        end
        apply_cycle(0, 1, 0, 1, s);
        n_vec++;
        if (s[8] !== 1'b1 || flush_a !== 16'd1 || flags_a[3:0] !== 4'b0011) begin
            n_err++;
            $display("FAIL mstall_release: got pc_we %b flush %0d valid %b expected 1 1 0011",
                     s[8], flush_a, flags_a[3:0]);
        end
    endtask

    task automatic test_saturation();
        logic [8:0] s;
        do_reset();
        run_normal(5);
        for (int i = 0; i < 20; i++) apply_cycle(0, 0, 1, 1, s);
        n_vec++;
        if (stall_b !== 4'd15 || stall_a !== 16'd20) begin
            n_err++;
            $display("FAIL saturate: got w4 %0d w16 %0d expected 15 20", stall_b, stall_a);
        end
        // Asynchronous reset in the middle of a stalled cycle.
        busy_in = 1'b1;
        #3;
        RST = 1'b1;
        #1;
        n_vec++;
        if ({flags_a, flags_b, stall_a, flush_a, stall_b, flush_b} !== 58'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b/%b %0d %0d %0d %0d expected all zero",
                     flags_a, flags_b, stall_a, flush_a, stall_b, flush_b);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_normal(4);
    endtask

    task automatic test_random();
        logic [8:0] s;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 1) begin
                do_reset();
            end else begin
                apply_cycle($urandom_range(99) < 20, $urandom_range(99) < 15,
                            $urandom_range(99) < 25, $urandom_range(99) < 85, s);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        lu_in = 0; ch_in = 0; busy_in = 0; fv_in = 0;
        #1;
        test_reset();
        test_load_use();
        test_control();
        test_ch_and_lu();
        test_mem_stall();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
